// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing/PWM path: FSM encoding and default widths.
package led_pkg;

  localparam int unsigned DUTY_W_DEFAULT = 16;
  localparam int unsigned CLK_HZ         = 27_000_000;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRise   = 3'd1,
    StHoldHi = 3'd2,
    StFall   = 3'd3,
    StHoldLo = 3'd4
  } breath_state_e;

endpackage

// File: rtl/tick_gen.sv
// Envelope tick divider: counts 0..TICK_DIV-1 while en is high and emits a one-cycle tick on the
// last count. clr returns the count to zero and has priority over en.
module tick_gen #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/breath_duty_seq.sv
// Breathing-envelope duty sequencer: rise/hold/fall/hold FSM over a linear level, optional
// square-law gamma, and a one-cycle registered output pipe feeding the PWM comparator.
module breath_duty_seq
  import led_pkg::*;
#(
  parameter int unsigned DUTY_W     = DUTY_W_DEFAULT,
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned STEP       = 200,
  parameter int unsigned HOLD_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pause,
  input  logic              gamma_en,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [2:0]        state,
  output logic              peak
);

  localparam logic [DUTY_W-1:0] LinMax  = '1;
  localparam logic [DUTY_W-1:0] StepW   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] RiseThr = LinMax - StepW;
  localparam int unsigned       HoldW   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam bit                NoHold  = (HOLD_TICKS == 0);

  breath_state_e     state_q, state_d;
  logic [DUTY_W-1:0] lin_q, lin_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              tick_q, tick_d;
  logic              peak_evt_q, peak_evt_d;
  logic              stop_q, stop_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;
  logic              peak_q, peak_d;

  logic                run;
  logic                tick;
  logic                hold_done;
  logic                peak_hit;
  logic                emit_tick;
  logic [2*DUTY_W-1:0] lin_ext;
  logic [2*DUTY_W-1:0] lin_sq;

  assign run       = enable && !pause;
  assign hold_done = (32'(hold_cnt_q) + 32'd1) >= HOLD_TICKS;
  assign lin_ext   = {{DUTY_W{1'b0}}, lin_q};
  assign lin_sq    = lin_ext * lin_ext;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (!enable),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      lin_q        <= '0;
      hold_cnt_q   <= '0;
      tick_q       <= 1'b0;
      peak_evt_q   <= 1'b0;
      stop_q       <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      peak_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lin_q        <= lin_d;
      hold_cnt_q   <= hold_cnt_d;
      tick_q       <= tick_d;
      peak_evt_q   <= peak_evt_d;
      stop_q       <= stop_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      peak_q       <= peak_d;
    end
  end

  // Next state and linear level; compare-before-step keeps lin from wrapping.
  always_comb begin
    state_d    = state_q;
    lin_d      = lin_q;
    hold_cnt_d = hold_cnt_q;
    peak_hit   = 1'b0;
    if (!enable) begin
      state_d    = StIdle;
      lin_d      = '0;
      hold_cnt_d = '0;
    end else if (!pause) begin
      unique case (state_q)
        StIdle: state_d = StRise;
        StRise: begin
          if (tick) begin
            if (lin_q >= RiseThr) begin
              lin_d    = LinMax;
              peak_hit = 1'b1;
              state_d  = NoHold ? StFall : StHoldHi;
            end else begin
              lin_d = lin_q + StepW;
            end
          end
        end
        StHoldHi: begin
          if (tick) begin
            if (hold_done) begin
              state_d    = StFall;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
          end
        end
        StFall: begin
          if (tick) begin
            if (lin_q <= StepW) begin
              lin_d   = '0;
              state_d = NoHold ? StRise : StHoldLo;
            end else begin
              lin_d = lin_q - StepW;
            end
          end
        end
        StHoldLo: begin
          if (tick) begin
            if (hold_done) begin
              state_d    = StRise;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output pipe: a pending tick is held (not dropped) across pause; disable discards it and
  // instead emits one zero-duty refresh the cycle after the FSM lands in idle.
  always_comb begin
    tick_d       = tick_q;
    peak_evt_d   = peak_evt_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    peak_d       = 1'b0;
    stop_d       = !enable && (state_q != StIdle);
    emit_tick    = tick_q && run;

    if (stop_q || emit_tick) begin
      duty_d       = gamma_en ? lin_sq[2*DUTY_W-1:DUTY_W] : lin_q;
      duty_valid_d = 1'b1;
      peak_d       = emit_tick && peak_evt_q;
    end

    if (run) begin
      tick_d     = tick && (state_q != StIdle);
      peak_evt_d = peak_hit;
    end else if (!enable) begin
      tick_d     = 1'b0;
      peak_evt_d = 1'b0;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign state      = state_q;
  assign peak       = peak_q;

endmodule

// File: tb/tb_breath_duty_seq.sv
// Scoreboard bench for breath_duty_seq: expected duty/peak pairs are queued as stimulus is applied
// and popped on every duty_valid pulse; a second instance covers the no-hold, full-step case.
module tb_breath_duty_seq;
  import led_pkg::*;

  typedef struct packed {
    logic [15:0] duty;
    logic        peak;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        gamma_en = 1'b0;
  logic        enable_b = 1'b0;
  logic [15:0] duty, duty_b;
  logic        duty_valid, duty_valid_b;
  logic        peak, peak_b;
  logic [2:0]  state, state_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  breath_duty_seq #(
    .DUTY_W     (16),
    .TICK_DIV   (4),
    .STEP       (32'h4000),
    .HOLD_TICKS (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pause      (pause),
    .gamma_en   (gamma_en),
    .duty       (duty),
    .duty_valid (duty_valid),
    .state      (state),
    .peak       (peak)
  );

  breath_duty_seq #(
    .DUTY_W     (16),
    .TICK_DIV   (4),
    .STEP       (32'hFFFF),
    .HOLD_TICKS (0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable_b),
    .pause      (1'b0),
    .gamma_en   (1'b0),
    .duty       (duty_b),
    .duty_valid (duty_valid_b),
    .state      (state_b),
    .peak       (peak_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t e(input logic [15:0] d, input logic p);
    exp_t x;
    x.duty = d;
    x.peak = p;
    return x;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t x;
    if (!rst) begin
      if (duty_valid) begin
        if (q_a.size() == 0) begin
          check("a_spurious_valid", 32'd1, 32'd0);
        end else begin
          x = q_a.pop_front();
          check("a_duty", duty, x.duty);
          check("a_peak", peak, x.peak);
        end
        if (peak) check("a_peak_state", state, StHoldHi);
      end else if (peak) begin
        check("a_peak_without_valid", 32'd1, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t x;
    if (!rst) begin
      if (duty_valid_b) begin
        if (q_b.size() == 0) begin
          check("b_spurious_valid", 32'd1, 32'd0);
        end else begin
          x = q_b.pop_front();
          check("b_duty", duty_b, x.duty);
          check("b_peak", peak_b, x.peak);
        end
        if (peak_b) check("b_peak_state", state_b, StFall);
      end else if (peak_b) begin
        check("b_peak_without_valid", 32'd1, 32'd0);
      end
    end
  end

  // Negedges from the call until the first duty_valid on instance a; -1 if none within budget.
  task automatic wait_pulse(input string tag, input int exp_n);
    int n;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (duty_valid) begin
        n = i;
        break;
      end
    end
    check(tag, n, exp_n);
  endtask

  task automatic drain(input string tag, input int limit);
    int i;
    i = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && i < limit) begin
      @(negedge clk);
      i++;
    end
    check(tag, q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_state", state, StIdle);
    check("rst_valid", duty_valid, 0);
    check("rst_peak", peak, 0);

    // Four enabled cycles to the tick, then one pipe stage.
    rst    = 1'b0;
    enable = 1'b1;
    q_a.push_back(e(16'h4000, 1'b0));
    wait_pulse("lat_first", 5);

    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_duty", duty, 0);
    check("async_rst_state", state, StIdle);
    check("async_rst_valid", duty_valid, 0);

    @(negedge clk);
    q_a.push_back(e(16'h4000, 1'b0));
    q_a.push_back(e(16'h8000, 1'b0));
    q_a.push_back(e(16'hC000, 1'b0));
    q_a.push_back(e(16'hFFFF, 1'b1));
    q_a.push_back(e(16'hFFFF, 1'b0));
    q_a.push_back(e(16'hFFFF, 1'b0));
    q_a.push_back(e(16'hBFFF, 1'b0));
    q_a.push_back(e(16'h7FFF, 1'b0));
    q_a.push_back(e(16'h3FFF, 1'b0));
    q_a.push_back(e(16'h0000, 1'b0));
    q_a.push_back(e(16'h0000, 1'b0));
    q_a.push_back(e(16'h0000, 1'b0));
    q_a.push_back(e(16'h4000, 1'b0));
    rst = 1'b0;
    wait_pulse("lat_after_rst", 5);
    drain("drain_ramp", 200);

    q_a.push_back(e(16'h0000, 1'b0));
    enable = 1'b0;
    @(negedge clk);
    check("drop_rise_state", state, StIdle);
    drain("drain_drop_rise", 10);
    repeat (8) @(negedge clk);

    gamma_en = 1'b1;
    enable   = 1'b1;
    q_a.push_back(e(16'h1000, 1'b0));
    q_a.push_back(e(16'h4000, 1'b0));
    q_a.push_back(e(16'h9000, 1'b0));
    q_a.push_back(e(16'hFFFE, 1'b1));
    drain("drain_gamma", 100);

    check("pre_drop_state", state, StHoldHi);
    q_a.push_back(e(16'h0000, 1'b0));
    enable = 1'b0;
    @(negedge clk);
    check("drop_hold_state", state, StIdle);
    check("drop_hold_valid_early", duty_valid, 0);
    drain("drain_drop_hold", 10);
    repeat (8) @(negedge clk);

    gamma_en = 1'b0;
    enable   = 1'b1;
    q_a.push_back(e(16'h4000, 1'b0));
    wait_pulse("lat_reenable", 5);

    // Two cycles after the pulse the divider sits at its last count; one cycle to the tick remains.
    repeat (2) @(negedge clk);
    pause    = 1'b1;
    gamma_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pause_duty", duty, 16'h4000);
      check("pause_valid", duty_valid, 0);
    end
    q_a.push_back(e(16'h4000, 1'b0));
    pause = 1'b0;
    wait_pulse("lat_resume", 2);
    gamma_en = 1'b0;
    q_a.push_back(e(16'hC000, 1'b0));
    q_a.push_back(e(16'hFFFF, 1'b1));
    drain("drain_resume", 100);

    q_a.push_back(e(16'h0000, 1'b0));
    enable = 1'b0;
    drain("drain_stop_a", 10);

    enable_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_b.push_back(e(16'hFFFF, 1'b1));
      q_b.push_back(e(16'h0000, 1'b0));
    end
    drain("drain_b", 100);
    q_b.push_back(e(16'h0000, 1'b0));
    enable_b = 1'b0;
    drain("drain_stop_b", 10);
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
